// File: rtl/evt_packet_rx.sv
// ---------------------------------------------------------------------------
// evt_packet_rx
//
// UART event-packet receiver. Deserialises an 8N1 serial stream, frames
// 5-byte event packets (sync, X, Y, polarity+timestamp high, timestamp low)
// and presents each decoded event on a single-entry valid/ready register.
// Bad stop bits, inter-byte timeouts and dropped packets are counted.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   uart_rx        in   1   asynchronous serial input, idle high
//   evt_valid      out  1   decoded event available
//   evt_ready      in   1   downstream accepts event
//   evt_x          out  8   event X coordinate
//   evt_y          out  8   event Y coordinate
//   evt_pol        out  1   event polarity
//   evt_ts         out  15  event timestamp
//   frame_err_cnt  out  8   saturating count of bad stop bits
//   timeout_cnt    out  8   saturating count of packets aborted by timeout
//   overflow_cnt   out  8   saturating count of packets dropped while held
// ---------------------------------------------------------------------------
module evt_packet_rx #(
  parameter int         CLK_FREQ_HZ         = 12_000_000,
  parameter int         BAUD_RATE           = 115_200,
  parameter logic [7:0] SYNC_BYTE           = 8'hA5,
  parameter int         BYTE_TIMEOUT_CYCLES = 20 * (CLK_FREQ_HZ / BAUD_RATE)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_x,
  output logic [7:0]  evt_y,
  output logic        evt_pol,
  output logic [14:0] evt_ts,
  output logic [7:0]  frame_err_cnt,
  output logic [7:0]  timeout_cnt,
  output logic [7:0]  overflow_cnt
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_CNT_W     = $clog2(BYTE_TIMEOUT_CYCLES + 1);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(HALF_BIT - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LAST   = TO_CNT_W'(BYTE_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_BREAK
  } bit_state_t;

  typedef enum logic [2:0] {
    P_HUNT,
    P_GET_X,
    P_GET_Y,
    P_GET_TSH,
    P_GET_TSL
  } pkt_state_t;

  bit_state_t bit_state, bit_next;
  pkt_state_t pkt_state, pkt_next;

  logic                 rx_meta, rx_sync, rx_prev;
  logic                 rx_fall;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;
  logic                 cnt_clear, shift_en;
  logic                 byte_stb, ferr_stb;

  logic [TO_CNT_W-1:0]  idle_cnt;
  logic [7:0]           x_buf, y_buf, tsh_buf;
  logic                 load_x, load_y, load_tsh;
  logic                 complete, timeout_hit, overflow_hit;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  // All flops reset to the idle-high line level so reset never fakes a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Bit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_state <= B_IDLE;
    end else begin
      bit_state <= bit_next;
    end
  end

  // Bit FSM next-state logic. START is checked at mid-bit so a short low
  // glitch returns to IDLE silently; every later sample is one bit period on,
  // i.e. at the middle of each data bit and of the stop bit. A low stop bit
  // parks in BREAK until the line returns high so the tail of a break
  // condition is not mistaken for a new start bit.
  always_comb begin
    bit_next  = bit_state;
    cnt_clear = 1'b0;
    shift_en  = 1'b0;
    byte_stb  = 1'b0;
    ferr_stb  = 1'b0;
    case (bit_state)
      B_IDLE: begin
        if (rx_fall) begin
          cnt_clear = 1'b1;
          bit_next  = B_START;
        end
      end
      B_START: begin
        if (bit_cnt == HALF_LAST) begin
          cnt_clear = 1'b1;
          bit_next  = rx_sync ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (bit_cnt == BIT_LAST) begin
          cnt_clear = 1'b1;
          shift_en  = 1'b1;
          if (bit_idx == 3'd7) begin
            bit_next = B_STOP;
          end
        end
      end
      B_STOP: begin
        if (bit_cnt == BIT_LAST) begin
          cnt_clear = 1'b1;
          if (rx_sync) begin
            byte_stb = 1'b1;
            bit_next = B_IDLE;
          end else begin
            ferr_stb = 1'b1;
            bit_next = B_BREAK;
          end
        end
      end
      B_BREAK: begin
        if (rx_sync) begin
          bit_next = B_IDLE;
        end
      end
      default: bit_next = B_IDLE;
    endcase
  end

  // Bit timing counter, data bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clear || bit_state == B_IDLE || bit_state == B_BREAK) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
      if (bit_state != B_DATA) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) begin
        shreg <= {rx_sync, shreg[7:1]};
      end
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state <= P_HUNT;
    end else begin
      pkt_state <= pkt_next;
    end
  end

  // Packet FSM next-state logic. Framing is positional: once a sync byte is
  // seen the next four bytes are data whatever their value. A frame error
  // wins over a coincident timeout so one broken byte is counted only once.
  always_comb begin
    pkt_next    = pkt_state;
    load_x      = 1'b0;
    load_y      = 1'b0;
    load_tsh    = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    if (ferr_stb) begin
      pkt_next = P_HUNT;
    end else if (byte_stb) begin
      case (pkt_state)
        P_HUNT: begin
          if (shreg == SYNC_BYTE) begin
            pkt_next = P_GET_X;
          end
        end
        P_GET_X: begin
          load_x   = 1'b1;
          pkt_next = P_GET_Y;
        end
        P_GET_Y: begin
          load_y   = 1'b1;
          pkt_next = P_GET_TSH;
        end
        P_GET_TSH: begin
          load_tsh = 1'b1;
          pkt_next = P_GET_TSL;
        end
        P_GET_TSL: begin
          complete = 1'b1;
          pkt_next = P_HUNT;
        end
        default: pkt_next = P_HUNT;
      endcase
    end else if (pkt_state != P_HUNT && idle_cnt == TO_LAST) begin
      timeout_hit = 1'b1;
      pkt_next    = P_HUNT;
    end
  end

  // Partial packet buffers and inter-byte idle counter. The idle counter
  // only runs while a packet is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_buf    <= '0;
      y_buf    <= '0;
      tsh_buf  <= '0;
      idle_cnt <= '0;
    end else begin
      if (load_x) x_buf <= shreg;
      if (load_y) y_buf <= shreg;
      if (load_tsh) tsh_buf <= shreg;
      if (pkt_state == P_HUNT || byte_stb || ferr_stb || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TO_CNT_W'(1);
      end
    end
  end

  assign overflow_hit = complete && evt_valid && !evt_ready;

  // Single-entry output register. A completing packet may replace an event
  // that is being accepted in the same cycle; otherwise the held event wins
  // and the new packet is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_x     <= '0;
      evt_y     <= '0;
      evt_pol   <= 1'b0;
      evt_ts    <= '0;
    end else begin
      if (complete && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_x     <= x_buf;
        evt_y     <= y_buf;
        evt_pol   <= tsh_buf[7];
        evt_ts    <= {tsh_buf[6:0], shreg};
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

  // Debug counters, each saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_cnt <= '0;
      timeout_cnt   <= '0;
      overflow_cnt  <= '0;
    end else begin
      if (ferr_stb && frame_err_cnt != 8'hFF) begin
        frame_err_cnt <= frame_err_cnt + 8'd1;
      end
      if (timeout_hit && timeout_cnt != 8'hFF) begin
        timeout_cnt <= timeout_cnt + 8'd1;
      end
      if (overflow_hit && overflow_cnt != 8'hFF) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/evt_packet_rx.md
# evt_packet_rx

UART event-packet receiver that sits directly upstream of the gesture core's event input in the UART-only build. It deserialises the PC's 8N1 serial stream, frames 5-byte event packets (sync, X, Y, polarity+timestamp high, timestamp low), and presents each decoded event on a single-entry valid/ready output register. Framing errors, inter-byte timeouts and output overflow are counted for debug.

## Interface
- CLK_FREQ_HZ, 12_000_000, system clock frequency
- BAUD_RATE, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division, 104 at defaults)
- SYNC_BYTE, 8'hA5, packet header byte
- BYTE_TIMEOUT_CYCLES, 20*CLKS_PER_BIT (2080), maximum idle cycles between bytes inside a packet

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- uart_rx  in  1  asynchronous serial input, idle high
- evt_valid  out  1  decoded event available
- evt_ready  in  1  downstream accepts event
- evt_x  out  8  event X coordinate
- evt_y  out  8  event Y coordinate
- evt_pol  out  1  event polarity
- evt_ts  out  15  event timestamp
- frame_err_cnt  out  8  saturating count of bad stop bits
- timeout_cnt  out  8  saturating count of packets aborted by timeout
- overflow_cnt  out  8  saturating count of packets dropped because evt_valid was held

## Operation
- Reset (async, rst_n low): all outputs 0; synchroniser flops 1; bit FSM IDLE; packet FSM HUNT; counters 0.
- uart_rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Bit FSM: IDLE -> START on high-to-low transition; START samples at CLKS_PER_BIT/2 cycles: 0 -> DATA, 1 -> IDLE (glitch, no error). DATA samples 8 bits LSB first, one every CLKS_PER_BIT cycles. STOP samples after a further CLKS_PER_BIT: 1 -> internal byte strobe + IDLE; 0 -> frame-error strobe + BREAK. BREAK waits for line high, then IDLE.
- Packet FSM states HUNT, GET_X, GET_Y, GET_TSH, GET_TSL, advanced only by byte strobes:
  - HUNT: byte == SYNC_BYTE -> GET_X; any other byte discarded.
  - GET_X / GET_Y capture X / Y. GET_TSH captures pol = bit7, ts[14:8] = bits[6:0]. GET_TSL captures ts[7:0], completes packet, -> HUNT.
  - Data bytes equal to SYNC_BYTE are treated as data (positional framing).
- Frame-error strobe in any state: frame_err_cnt++, packet FSM -> HUNT, partial packet discarded.
- Timeout: idle counter cleared on every byte strobe and in HUNT; in GET_* states reaching BYTE_TIMEOUT_CYCLES -> HUNT, timeout_cnt++.
- Completion: if evt_valid is 0, or evt_valid && evt_ready in the same cycle, load evt_* and set evt_valid. Otherwise drop the new packet, overflow_cnt++; held event unchanged.
- All counters saturate at 255 and never wrap.

## Timing
- Byte strobe occurs 2 synchroniser cycles + ~9.5 bit-times after the start edge.
- evt_valid rises the cycle after the GET_TSL byte strobe; no combinational path from uart_rx or evt_ready to any output.
- Handshake: transfer on clk edge with evt_valid && evt_ready. evt_valid falls the next cycle unless a completion coincides. evt_* stable while evt_valid && !evt_ready.
- Counter increments are visible one cycle after the causing strobe.
- Reset mid-byte or mid-packet aborts immediately; the next valid start edge after release begins fresh in HUNT.

## Test plan
- Send A5 12 34 85 67 at 115200, evt_ready=1 -> one evt_valid pulse; x=0x12, y=0x34, pol=1, ts=0x0567; all counters 0.
- Send 00 FF A5 A5 A5 80 01 -> junk discarded; one event x=0xA5, y=0xA5, pol=1, ts=0x0001.
- Send A5 11, idle 3000 cycles, then A5 01 02 03 04 -> timeout_cnt=1; one event x=01, y=02, pol=0, ts=0x0304.
- Send A5 11 with stop bit forced 0 on byte 2, then a full packet -> frame_err_cnt=1; only the full packet is emitted.
- evt_ready=0, send packets P1 then P2 -> evt_* holds P1, overflow_cnt=1; raise evt_ready -> P1 transferred, evt_valid low next cycle.
- 1-cycle low glitch on idle uart_rx; assert rst_n low mid-packet -> no byte, no error; outputs and counters 0 immediately, next packet decodes correctly.
